// File: rtl/bus_dma.sv
// Purpose: bus-master DMA that copies `length` 32-bit words from src_addr.. to dst_addr.. over a shared bus.
// Latency: 1 (REQ) + 3 per word (RD/CAP/WR) + 1 (DONE) cycles after an accepted start when grant is held.
// Backpressure: M_grant low freezes the sequencer in place; the bus is held from REQ through the last write.
//
// Ports:
//   clk, reset                   : single clock, synchronous active-high reset
//   start, src_addr, dst_addr,
//   length                       : copy request, sampled only while idle
//   M_grant, M_din               : arbiter grant and read data from the bus
//   M_req, M_wr, M_address,
//   M_dout                       : registered bus request, direction, address and write data
//   busy, done                   : registered status; done is a one-cycle completion pulse
module bus_dma (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  src_addr,
    input  logic [7:0]  dst_addr,
    input  logic [7:0]  length,
    input  logic        M_grant,
    input  logic [31:0] M_din,
    output logic        M_req,
    output logic        M_wr,
    output logic [7:0]  M_address,
    output logic [31:0] M_dout,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  src_q;
    logic [7:0]  dst_q;
    logic [7:0]  cnt_q;
    logic [31:0] data_q;

    logic [7:0]  src_nxt;
    logic [7:0]  dst_nxt;
    logic [7:0]  cnt_nxt;
    logic [31:0] data_nxt;

    logic        req_nxt;
    logic        wr_nxt;
    logic [7:0]  addr_nxt;
    logic [31:0] dout_nxt;
    logic        busy_nxt;
    logic        done_nxt;

    // A word is written only on a cycle where the registered write strobe is
    // already on the bus and the arbiter grants it. After a grant gap M_wr is
    // re-raised first, so the resumed write is a full, visible bus cycle.
    logic        wr_commit;
    assign wr_commit = (state == WR) && M_grant && M_wr;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (length == 8'd0) ? DONE : REQ;
                end
            end
            REQ:  if (M_grant) state_nxt = RD;
            RD:   if (M_grant) state_nxt = CAP;
            CAP:  if (M_grant) state_nxt = WR;
            WR: begin
                if (wr_commit) begin
                    state_nxt = (cnt_q == 8'd1) ? DONE : RD;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath logic: everything is computed for the next state so
    // the bus outputs can be registered with no combinational path to ports.
    always_comb begin
        src_nxt  = src_q;
        dst_nxt  = dst_q;
        cnt_nxt  = cnt_q;
        data_nxt = data_q;

        if (state == IDLE && start && length != 8'd0) begin
            src_nxt = src_addr;
            dst_nxt = dst_addr;
            cnt_nxt = length;
        end
        if (state == CAP && M_grant) begin
            data_nxt = M_din;
        end
        if (wr_commit) begin
            src_nxt = src_q + 8'd1;
            dst_nxt = dst_q + 8'd1;
            cnt_nxt = cnt_q - 8'd1;
        end

        req_nxt  = (state_nxt == REQ) || (state_nxt == RD) ||
                   (state_nxt == CAP) || (state_nxt == WR);
        busy_nxt = req_nxt;
        done_nxt = (state_nxt == DONE);
        // Grant is the best predictor of whether the next cycle may write.
        wr_nxt   = (state_nxt == WR) && M_grant;

        case (state_nxt)
            RD, CAP: addr_nxt = src_nxt;
            WR:      addr_nxt = dst_nxt;
            default: addr_nxt = 8'd0;
        endcase
        dout_nxt = (state_nxt == WR) ? data_nxt : 32'd0;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q     <= 8'd0;
            dst_q     <= 8'd0;
            cnt_q     <= 8'd0;
            data_q    <= 32'd0;
            M_req     <= 1'b0;
            M_wr      <= 1'b0;
            M_address <= 8'd0;
            M_dout    <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            src_q     <= src_nxt;
            dst_q     <= dst_nxt;
            cnt_q     <= cnt_nxt;
            data_q    <= data_nxt;
            M_req     <= req_nxt;
            M_wr      <= wr_nxt;
            M_address <= addr_nxt;
            M_dout    <= dout_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

endmodule
